// File: rtl/lsu_multicycle.sv
// Multi-cycle RV64 load/store unit between the execute stage and a handshaked memory port.
// Handles access sizing, byte-lane steering, load extension, misalignment and bus timeout.
module lsu_multicycle #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic [1:0]      resp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [7:0]      mem_wmask,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_we;
   logic [2:0]        r_op;
   logic [2:0]        r_sh;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [7:0]        r_wmask;
   logic [XLEN-1:0]   r_rdata;
   logic [1:0]        r_err;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_bad;
   logic              w_lim;
   logic              w_capture;
   logic              w_timeout;

   function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] sh);
      logic [7:0] m;
      case (sz)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << sh;
   endfunction

   function automatic logic is_bad(input logic [2:0] op, input logic [2:0] a);
      logic bad;
      case (op[1:0])
         2'd0:    bad = 1'b0;
         2'd1:    bad = a[0];
         2'd2:    bad = |a[1:0];
         default: bad = |a;
      endcase
      return bad || (op == 3'b111);
   endfunction

   // Selected lane is moved to bit 0, then sign- or zero-extended by op[2].
   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] op, input logic [2:0] sh,
                                                input logic [XLEN-1:0] d);
      logic [XLEN-1:0] raw;
      logic [XLEN-1:0] res;
      raw = d >> {sh, 3'b000};
      case (op)
         3'b000:  res = {{(XLEN-8){raw[7]}}, raw[7:0]};
         3'b001:  res = {{(XLEN-16){raw[15]}}, raw[15:0]};
         3'b010:  res = {{(XLEN-32){raw[31]}}, raw[31:0]};
         3'b100:  res = {{(XLEN-8){1'b0}}, raw[7:0]};
         3'b101:  res = {{(XLEN-16){1'b0}}, raw[15:0]};
         3'b110:  res = {{(XLEN-32){1'b0}}, raw[31:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   assign w_bad = is_bad(req_op, req_addr[2:0]);
   assign w_lim = (r_cnt == CNT_LIM);

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) w_state_nxt = w_bad ? S_RESP : S_REQ;
         end
         // Completion is tested before the limit so a same-cycle finish still reports ok.
         S_REQ: begin
            if (mem_gnt && (r_we || mem_rvalid)) begin
               w_state_nxt = S_RESP;
               w_capture   = !r_we;
            end else if (w_lim) begin
               w_state_nxt = S_RESP;
               w_timeout   = 1'b1;
            end else if (mem_gnt) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               w_state_nxt = S_RESP;
               w_capture   = 1'b1;
            end else if (w_lim) begin
               w_state_nxt = S_RESP;
               w_timeout   = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_op    <= 3'b000;
         r_sh    <= 3'b000;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= 8'h00;
         r_rdata <= '0;
         r_err   <= 2'b00;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && req_valid) begin
            r_we    <= req_we && !w_bad;
            r_op    <= req_op;
            r_sh    <= req_addr[2:0];
            r_addr  <= {req_addr[XLEN-1:3], 3'b000};
            r_wdata <= req_wdata << {req_addr[2:0], 3'b000};
            r_wmask <= req_we ? lane_mask(req_op[1:0], req_addr[2:0]) : 8'h00;
            r_rdata <= '0;
            r_err   <= w_bad ? 2'b01 : 2'b00;
            r_cnt   <= '0;
         end
         if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
         if (w_capture) r_rdata <= load_ext(r_op, r_sh, mem_rdata);
         if (w_timeout) r_err <= 2'b10;
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   assign mem_req    = (r_state == S_REQ);
   assign mem_we     = r_we;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
   assign mem_wmask  = r_wmask;

endmodule

// File: tb/tb_lsu_multicycle.sv
// Bench for lsu_multicycle: directed corner cases plus randomized traffic against
// an arithmetic reference model of sizing, lane steering, extension and timeout.
module tb_lsu_multicycle;
   localparam int XLEN = 64;
   localparam int TO   = 8;
   localparam int CW   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, req_we;
   logic [2:0]      req_op;
   logic [XLEN-1:0] req_addr, req_wdata;
   logic            resp_valid, resp_ready;
   logic [XLEN-1:0] resp_rdata;
   logic [1:0]      resp_err;
   logic            mem_req, mem_we;
   logic [XLEN-1:0] mem_addr, mem_wdata;
   logic [7:0]      mem_wmask;
   logic            mem_gnt, mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   int n_vec  = 0;
   int n_miss = 0;

   lsu_multicycle #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic we, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] mrd,
                        output logic mis, output logic [7:0] mask,
                        output logic [63:0] wd, output logic [63:0] rd);
      int size, sh;
      logic [63:0] keep, raw;
      size = 1 << op[1:0];
      sh   = int'(addr % 8);
      mis  = (op == 3'b111) || (addr % size != 0);
      mask = we ? 8'(((1 << size) - 1) << sh) : 8'h00;
      wd   = wdata << (8 * sh);
      keep = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
      raw  = (mrd >> (8 * sh)) & keep;
      if (!op[2] && size < 8 && raw[8*size-1]) raw = raw | ~keep;
      rd = raw;
   endtask

   // gd: cycles after accept before grant; rd: cycles after grant before read data.
   task automatic do_txn(input logic we, input logic [2:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] mrd,
                         input int gd, input int rd, input int hold,
                         output logic [63:0] o_rdata, output logic [1:0] o_err, output int o_lat,
                         output logic [7:0] o_mask, output logic [63:0] o_wdata,
                         output logic [63:0] o_addr);
      logic mis, tmo, done;
      logic [7:0] emask;
      logic [63:0] ewd, erd, e_rdata;
      logic [1:0] e_err;
      int e_lat;
      model(we, op, addr, wdata, mrd, mis, emask, ewd, erd);
      tmo     = !mis && ((we ? gd : gd + rd) > TO - 1);
      e_err   = mis ? 2'b01 : (tmo ? 2'b10 : 2'b00);
      e_rdata = (mis || tmo || we) ? 64'd0 : erd;
      e_lat   = mis ? 1 : (tmo ? TO + 1 : gd + (we ? 0 : rd) + 2);
      o_mask = 8'h00; o_wdata = 64'd0; o_addr = 64'd0; o_lat = 0;
      check_eq("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
      tick();
      req_valid = 1'b0;
      done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         check_eq("mem_req", mem_req, !mis && cyc <= gd && cyc < e_lat - 1);
         if (resp_valid) begin
            done  = 1'b1;
            o_lat = cyc + 1;
         end else begin
            if (mem_req) begin
               check_eq("mem_addr", mem_addr, {addr[63:3], 3'b000});
               check_eq("mem_we", mem_we, we);
               check_eq("mem_wmask", mem_wmask, emask);
               if (we) check_eq("mem_wdata", mem_wdata, ewd);
               o_mask = mem_wmask; o_wdata = mem_wdata; o_addr = mem_addr;
            end
            mem_gnt    = (cyc == gd);
            mem_rvalid = !we && !mis && (cyc == gd + rd);
            mem_rdata  = mem_rvalid ? mrd : {$urandom, $urandom};
            tick();
         end
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check_eq("resp_seen", done, 1);
      check_eq("latency", o_lat, e_lat);
      check_eq("resp_rdata", resp_rdata, e_rdata);
      check_eq("resp_err", resp_err, e_err);
      o_rdata = resp_rdata;
      o_err   = resp_err;
      for (int h = 0; h < hold; h++) begin
         resp_ready = 1'b0;
         tick();
         check_eq("hold_valid", resp_valid, 1);
         check_eq("hold_rdata", resp_rdata, e_rdata);
         check_eq("hold_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check_eq("resp_drop", resp_valid, 0);
      check_eq("back_idle", req_ready, 1);
   endtask

   initial begin
      logic [63:0] r, w, a;
      logic [7:0]  m;
      logic [1:0]  e;
      int          l;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      tick(); tick();
      check_eq("rst_req_ready", req_ready, 1);
      check_eq("rst_mem_req", mem_req, 0);
      check_eq("rst_resp_valid", resp_valid, 0);
      check_eq("rst_resp_err", resp_err, 0);
      check_eq("rst_wmask", mem_wmask, 0);
      rst = 1'b0;
      tick();

      do_txn(1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h1122_3344_8566_7788, 0, 1, 0, r, e, l, m, w, a);
      check_eq("lb_rdata", r, 64'hFFFF_FFFF_FFFF_FF85);
      check_eq("lb_lat", l, 3);
      do_txn(1'b0, 3'b100, 64'h8000_0003, 64'd0, 64'h1122_3344_8566_7788, 0, 1, 0, r, e, l, m, w, a);
      check_eq("lbu_rdata", r, 64'h0000_0000_0000_0085);

      do_txn(1'b1, 3'b001, 64'h8000_0006, 64'hABCD, 64'd0, 4, 0, 0, r, e, l, m, w, a);
      check_eq("sh_wmask", m, 8'hC0);
      check_eq("sh_wdata", w, 64'hABCD_0000_0000_0000);
      check_eq("sh_addr", a, 64'h8000_0000);
      check_eq("sh_err", e, 2'b00);

      do_txn(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 1, 0, r, e, l, m, w, a);
      check_eq("lw_mis_err", e, 2'b01);
      check_eq("lw_mis_lat", l, 1);
      do_txn(1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 0, 1, 0, r, e, l, m, w, a);
      check_eq("op111_err", e, 2'b01);

      do_txn(1'b0, 3'b011, 64'h8000_0040, 64'd0, 64'h55, 0, 100, 0, r, e, l, m, w, a);
      check_eq("tmo_err", e, 2'b10);
      check_eq("tmo_lat", l, TO + 1);
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = {$urandom, $urandom};
      tick();
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      check_eq("late_rvalid_idle", req_ready, 1);
      check_eq("late_rvalid_resp", resp_valid, 0);
      check_eq("late_rvalid_req", mem_req, 0);

      do_txn(1'b0, 3'b011, 64'h8000_0048, 64'd0, 64'h1234, 3, 4, 0, r, e, l, m, w, a);
      check_eq("edge_ok_err", e, 2'b00);
      check_eq("edge_ok_rdata", r, 64'h1234);
      do_txn(1'b0, 3'b011, 64'h8000_0048, 64'd0, 64'h1234, 3, 5, 0, r, e, l, m, w, a);
      check_eq("edge_tmo_err", e, 2'b10);
      do_txn(1'b1, 3'b011, 64'h8000_0050, 64'h77, 64'd0, 100, 0, 0, r, e, l, m, w, a);
      check_eq("st_tmo_err", e, 2'b10);

      do_txn(1'b0, 3'b010, 64'h8000_0004, 64'd0, 64'h8000_0001_0000_0000, 0, 1, 5, r, e, l, m, w, a);
      check_eq("bp_lw_rdata", r, 64'hFFFF_FFFF_8000_0001);

      req_valid = 1'b1; req_we = 1'b0; req_op = 3'b011; req_addr = 64'h8000_0010;
      tick();
      req_valid = 1'b0; mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check_eq("wait_mem_req", mem_req, 0);
      check_eq("wait_addr", mem_addr, 64'h8000_0010);
      check_eq("wait_resp", resp_valid, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_ready", req_ready, 1);
      check_eq("mid_rst_req", mem_req, 0);
      check_eq("mid_rst_addr", mem_addr, 0);
      check_eq("mid_rst_we", mem_we, 0);
      check_eq("mid_rst_wdata", mem_wdata, 0);
      check_eq("mid_rst_resp", resp_valid, 0);
      check_eq("mid_rst_rdata", resp_rdata, 0);
      check_eq("mid_rst_err", resp_err, 0);

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic [63:0] addr;
         int sz, sh, gd, rd;
         op = 3'($urandom_range(0, 7));
         sz = 1 << op[1:0];
         sh = int'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) sh = sh & ~(sz - 1);
         addr = {$urandom, $urandom};
         addr[2:0] = 3'(sh);
         gd = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
         rd = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
         do_txn(1'($urandom_range(0, 1)), op, addr, {$urandom, $urandom}, {$urandom, $urandom},
                gd, rd, int'($urandom_range(0, 2)), r, e, l, m, w, a);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
